// File: rtl/axi_rd_mem_adapter.sv
// AXI read-channel slave driving a single-word synchronous SRAM read port.
// Bursts are split into beats, buffered in a 2-entry R FIFO with in-flight accounting.
module axi_rd_mem_adapter #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            ar_valid,
    output logic                                            ar_ready,
    input  logic [ID_WIDTH-1:0]                             ar_id,
    input  logic [ADDR_WIDTH-1:0]                           ar_addr,
    input  logic [7:0]                                      ar_len,
    input  logic [2:0]                                      ar_size,
    input  logic [1:0]                                      ar_burst,
    output logic                                            r_valid,
    input  logic                                            r_ready,
    output logic [ID_WIDTH-1:0]                             r_id,
    output logic [DATA_WIDTH-1:0]                           r_data,
    output logic [1:0]                                      r_resp,
    output logic                                            r_last,
    output logic                                            mem_req,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]      mem_addr,
    input  logic [DATA_WIDTH-1:0]                           mem_rdata
);

    localparam int LOG_B = $clog2(DATA_WIDTH/8);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } beat_t;

    logic [0:0]            state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic [7:0]            beat_q;
    logic                  infl_q;
    logic [ID_WIDTH-1:0]   infl_id_q;
    logic                  infl_last_q;
    logic [1:0]            cnt_q, cnt_d;
    beat_t                 head_q, head_d;
    beat_t                 tail_q, tail_d;

    logic                  ar_fire;
    logic                  ar_bad;
    logic                  pop;
    logic                  slot_ok;
    logic                  issue;
    logic                  last_beat;
    logic                  push;
    beat_t                 push_beat;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [1:0]            cnt_after_pop;

    assign ar_ready  = (state_q == S_IDLE) && !rst;
    assign ar_fire   = ar_valid && ar_ready;
    assign r_valid   = (cnt_q != 2'd0) && !rst;
    assign pop       = r_valid && r_ready;
    assign slot_ok   = ({1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop}) < 3'd2;
    assign issue     = (state_q == S_BURST) && slot_ok && !rst;
    assign mem_req   = issue && !err_q;
    assign last_beat = (beat_q == len_q);
    assign mem_addr  = addr_q[ADDR_WIDTH-1:LOG_B];

    assign r_id   = r_valid ? head_q.id   : '0;
    assign r_data = r_valid ? head_q.data : '0;
    assign r_resp = r_valid ? head_q.resp : 2'b00;
    assign r_last = r_valid ? head_q.last : 1'b0;

    assign ar_bad = (ar_burst == 2'd3)
                 || ((ar_burst == 2'd2) && !((ar_len == 8'd1) || (ar_len == 8'd3)
                                          || (ar_len == 8'd7) || (ar_len == 8'd15)))
                 || (ar_size > 3'(LOG_B));

    // next beat address for FIXED / INCR / WRAP
    always_comb begin
        incr     = ADDR_WIDTH'(1) << size_q;
        wmask    = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        addr_nxt = addr_q;
        unique case (burst_q)
            2'd1:    addr_nxt = addr_q + incr;
            2'd2:    addr_nxt = (addr_q & ~wmask) | ((addr_q + incr) & wmask);
            default: addr_nxt = addr_q;
        endcase
    end

    // error beats enter the buffer at issue; memory beats one cycle later
    always_comb begin
        push      = (issue && err_q) || infl_q;
        push_beat = '0;
        if (infl_q) begin
            push_beat.id   = infl_id_q;
            push_beat.data = mem_rdata;
            push_beat.resp = 2'b00;
            push_beat.last = infl_last_q;
        end else begin
            push_beat.id   = id_q;
            push_beat.data = '0;
            push_beat.resp = 2'b10;
            push_beat.last = last_beat;
        end
    end

    // two-entry FIFO; head feeds the R channel directly
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        cnt_after_pop = cnt_q;
        if (pop) begin
            head_d        = tail_q;
            cnt_after_pop = cnt_q - 2'd1;
        end
        cnt_d = cnt_after_pop;
        if (push) begin
            if (cnt_after_pop == 2'd0) head_d = push_beat;
            else                       tail_d = push_beat;
            cnt_d = cnt_after_pop + 2'd1;
        end
    end

    // IDLE accepts one AR, BURST issues until beat len
    always_comb begin
        state_d = state_q;
        if (ar_fire)                 state_d = S_BURST;
        else if (issue && last_beat) state_d = S_IDLE;
    end

    // state, burst context, in-flight tracking and buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
            beat_q      <= '0;
            infl_q      <= 1'b0;
            infl_id_q   <= '0;
            infl_last_q <= 1'b0;
            cnt_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            infl_q      <= mem_req;
            infl_id_q   <= id_q;
            infl_last_q <= last_beat;
            if (ar_fire) begin
                id_q    <= ar_id;
                addr_q  <= ar_addr;
                len_q   <= ar_len;
                size_q  <= ar_size;
                burst_q <= ar_burst;
                err_q   <= ar_bad;
                beat_q  <= '0;
            end else if (issue) begin
                addr_q  <= addr_nxt;
                beat_q  <= beat_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_mem_adapter.sv
// Bench for axi_rd_mem_adapter: SRAM model, burst scoreboard,
// directed latency/reset cases and randomized bursts under R backpressure.
module tb_axi_rd_mem_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid;
    logic        ar_ready;
    logic [7:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic [7:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        mem_req;
    logic [28:0] mem_addr;
    logic [63:0] mem_rdata;

    axi_rd_mem_adapter #(
        .ID_WIDTH   (8),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_id     (ar_id),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_size   (ar_size),
        .ar_burst  (ar_burst),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_id      (r_id),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_last    (r_last),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      exp_q[$];
    logic [28:0] waddr_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    int          rr_mode = 0;
    int          rr_phase = 0;
    int          issued = 0;
    int          popped_n = 0;
    logic        stall_prev = 1'b0;
    logic [74:0] prev_r;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] memval(input logic [28:0] w);
        return {w ^ 29'h1ABCDE, 3'b101, ~w + 29'd7, 3'b011};
    endfunction

    // SRAM model: data exactly one cycle after the strobe, junk otherwise
    always @(posedge clk)
        mem_rdata <= mem_req ? memval(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

    // R backpressure patterns
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0: r_ready = 1'b1;
            1: begin
                r_ready  = (rr_phase % 4 == 0) || (rr_phase % 4 == 3);
                rr_phase = rr_phase + 1;
            end
            default: r_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // expected beats from the burst rules, computed per beat index
    task automatic model_burst(input logic [7:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
        logic        bad;
        logic [31:0] inc, mask, a, bb;
        rbeat_t      e;
        bad  = (burst == 2'd3)
            || (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15))
            || (size > 3'd3);
        inc  = 32'd1 << size;
        mask = ((32'(len) + 32'd1) << size) - 32'd1;
        for (int b = 0; b <= int'(len); b++) begin
            bb = 32'(b);
            case (burst)
                2'd0:    a = addr;
                2'd1:    a = addr + bb * inc;
                default: a = (addr & ~mask) | ((addr + bb * inc) & mask);
            endcase
            e.id   = id;
            e.last = (b == int'(len));
            if (bad) begin
                e.data = 64'd0;
                e.resp = 2'b10;
            end else begin
                e.data = memval(a[31:3]);
                e.resp = 2'b00;
                waddr_q.push_back(a[31:3]);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        bit got;
        model_burst(id, addr, len, size, burst);
        @(posedge clk);
        #1;
        ar_valid = 1'b1;
        ar_id    = id;
        ar_addr  = addr;
        ar_len   = len;
        ar_size  = size;
        ar_burst = burst;
        got      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ar_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("ar_timeout", 0, 1);
        @(posedge clk);
        #1;
        ar_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !r_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic first_rvalid(input string tag, input int want);
        int k;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (r_valid) begin
                k = i;
                break;
            end
        end
        chk(tag, k, want);
    endtask

    // scoreboard: memory addresses, R beats, slot rule, R stability
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_req) begin
                chk("slot_rule",
                    (issued - popped_n - int'(r_valid && r_ready && r_resp == 2'b00)) < 2, 1);
                issued++;
                if (waddr_q.size() == 0) chk("mem_req_unexpected", 1, 0);
                else chk("mem_addr", mem_addr, waddr_q.pop_front());
            end
            if (stall_prev)
                chk("r_stable", {r_valid, r_id, r_data, r_resp, r_last}, {1'b1, prev_r});
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0) chk("r_unexpected", 1, 0);
                else chk("r_beat", {r_id, r_data, r_resp, r_last}, exp_q.pop_front());
                if (r_resp == 2'b00) popped_n++;
            end
            stall_prev = r_valid && !r_ready;
            prev_r     = {r_id, r_data, r_resp, r_last};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  bt;
        logic [7:0]  ln;
        logic [2:0]  sz;
        logic [31:0] ad;
        rst      = 1'b1;
        ar_valid = 1'b0;
        ar_id    = '0;
        ar_addr  = '0;
        ar_len   = '0;
        ar_size  = '0;
        ar_burst = '0;
        r_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_r_fields", {r_id, r_data, r_resp, r_last}, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("idle_ar_ready", ar_ready, 1);

        rr_mode = 0;
        send_ar(8'h11, 32'h1000, 8'd3, 3'd3, 2'd1);
        first_rvalid("lat_incr", 3);
        wait_drain();

        send_ar(8'h22, 32'h1018, 8'd3, 3'd3, 2'd2);
        wait_drain();
        send_ar(8'h33, 32'h40, 8'd2, 3'd3, 2'd0);
        wait_drain();

        send_ar(8'h44, 32'h80, 8'd1, 3'd3, 2'd3);
        first_rvalid("lat_err", 2);
        wait_drain();
        send_ar(8'h55, 32'h100, 8'd2, 3'd3, 2'd2);
        wait_drain();
        send_ar(8'h56, 32'h100, 8'd1, 3'd4, 2'd1);
        wait_drain();

        rr_mode  = 1;
        rr_phase = 0;
        send_ar(8'h66, 32'h3000, 8'd7, 3'd3, 2'd1);
        wait_drain();
        send_ar(8'h67, 32'hFFFF_FFF0, 8'd3, 3'd3, 2'd1);
        wait_drain();

        rr_mode = 0;
        send_ar(8'h77, 32'h2000, 8'd15, 3'd3, 2'd1);
        repeat (5) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b0;
        @(negedge clk);
        chk("mid_rst_r_valid", r_valid, 0);
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_ar_ready", ar_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_quiet", {r_valid, mem_req, ar_ready, r_id, r_data, r_resp, r_last}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        waddr_q.delete();
        issued     = 0;
        popped_n   = 0;
        stall_prev = 1'b0;
        mon_en     = 1'b1;
        @(negedge clk);
        chk("post_rst_ar_ready", ar_ready, 1);
        chk("post_rst_r_valid", r_valid, 0);
        send_ar(8'h88, 32'h4000, 8'd3, 3'd3, 2'd1);
        wait_drain();

        for (int n = 0; n < 40; n++) begin
            rr_mode = $urandom_range(0, 2);
            bt      = 2'($urandom_range(0, 3));
            ln      = 8'($urandom_range(0, 15));
            if (bt == 2'd2 && $urandom_range(0, 3) != 0)
                ln = 8'((1 << $urandom_range(1, 4)) - 1);
            sz = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) sz = 3'($urandom_range(4, 7));
            ad = $urandom;
            if ($urandom_range(0, 5) == 0) ad = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            send_ar(8'($urandom), ad, ln, sz, bt);
        end
        wait_drain();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_addr_queue_empty", waddr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
